// File: rtl/fpu_sequencer.sv
// Purpose: buffers tagged fpu commands in a FIFO and sequences each one through a registered external fpu.
// Latency: 3 clk edges from acceptance (idle, empty) to out_valid; one result every 3 cycles sustained.
// Backpressure: in_ready = !full; a result held by out_ready=0 stalls issue while the FIFO absorbs commands.
module fpu_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_opcode,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [3:0]  in_tag,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [1:0]  fpu_opcode,
    input  logic [31:0] fpu_o,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_tag,
    output logic [2:0]  out_flags,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [1:0]  opcode;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    cmd_t          mem [DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          empty;
    logic          push;
    logic          load;
    logic          capture;
    logic          done;
    logic [3:0]    tag_q;
    state_t        state;
    state_t        state_nxt;

    // {nan, inf, zero} classification; sign bit deliberately ignored
    function automatic logic [2:0] fp_flags(input logic [31:0] v);
        logic exp_ones;
        logic exp_zero;
        logic frac_zero;
        exp_ones  = &v[30:23];
        exp_zero  = ~|v[30:23];
        frac_zero = ~|v[22:0];
        return {exp_ones & ~frac_zero, exp_ones & frac_zero, exp_zero & frac_zero};
    endfunction

    // ready depends on occupancy only, so a same-cycle pop never opens a full FIFO
    assign in_ready = (count != FULL_CNT);
    assign empty    = (count == '0);
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];
    assign busy     = !empty || (state != IDLE);
    assign done     = (state == RESP) && out_ready;

    // command storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_t'{opcode: in_opcode, a: in_a, b: in_b, tag: in_tag};
        end
    end

    // pointers wrap naturally at the power-of-two depth; load is the only pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (load) rd_ptr <= rd_ptr + AW'(1);
            case ({push, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state and per-state strobes; RESP can chain straight into the next issue
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: begin
                capture   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (out_ready) begin
                    if (!empty) begin
                        load      = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // operand registers for the fpu: change only when a new command is loaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpu_a      <= '0;
            fpu_b      <= '0;
            fpu_opcode <= '0;
            tag_q      <= '0;
        end else if (load) begin
            fpu_a      <= head.a;
            fpu_b      <= head.b;
            fpu_opcode <= head.opcode;
            tag_q      <= head.tag;
        end
    end

    // result registers: captured one edge after the fpu samples, held until accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_flags  <= '0;
        end else if (capture) begin
            out_valid  <= 1'b1;
            out_result <= fpu_o;
            out_tag    <= tag_q;
            out_flags  <= fp_flags(fpu_o);
        end else if (done) begin
            out_valid  <= 1'b0;
        end
    end
endmodule
